frame_write_ctrl: RTL and testbench

- Write-side feeder for the DDR3 burst controller. Drains one camera pixel FIFO (already in the memory clock domain) into a frame buffer.
- Issues fixed-length write bursts into one of NUM_BUFS frame buffers per frame, then reports the last completed buffer to the read side.
- Sits directly upstream of the controller's wr_burst_* port.

---
 rtl/frame_write_ctrl.sv | 156 +++++++++++++++
 tb/tb_frame_write_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_ctrl.sv
// Drains the camera pixel FIFO into rotating DDR3 frame buffers as fixed-length write bursts.
// Latency: request one cycle after the FIFO holds a chunk; backpressure via fifo_rdusedw gating and wr_burst_data_req.
// Optional FRAME_WRITE_STAT_EN adds frame_cnt/drop_cnt statistics outputs.
module frame_write_ctrl #(
    parameter int                   MEM_DATA_BITS = 64,
    parameter int                   ADDR_BITS     = 24,
    parameter int                   BURST_LEN     = 128,
    parameter int                   FRAME_WORDS   = 76800,
    parameter logic [ADDR_BITS-1:0] FRAME_STRIDE  = 24'h020000,
    parameter int                   NUM_BUFS      = 3,
    parameter int                   CLR_CYCLES    = 8
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     calib_done,
    input  logic                     frame_start,
    output logic                     fifo_aclr,
    input  logic [10:0]              fifo_rdusedw,
    output logic                     fifo_rd_en,
    input  logic [MEM_DATA_BITS-1:0] fifo_q,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    output logic                     frame_done,
    output logic [1:0]               last_buf
`ifdef FRAME_WRITE_STAT_EN
    ,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLR, WAIT, BURST, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          clr_cnt;
    logic [RW-1:0]          remaining;
    logic [RW-1:0]          rem_after;
    logic [ADDR_BITS-1:0]   addr;
    logic [1:0]             buf_idx;
    logic                   pending;
    logic [9:0]             chunk;
    logic                   abort;

    always_comb begin
        chunk = 10'(remaining);
        if (32'(remaining) > 32'(BURST_LEN))
            chunk = 10'(BURST_LEN);
    end

    assign rem_after = remaining - RW'(wr_burst_len);

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: if (frame_start && calib_done) state_nxt = CLR;
            CLR: begin
                if (!calib_done)
                    state_nxt = IDLE;
                else if (frame_start) begin
                    state_nxt = CLR;
                    abort     = 1'b1;
                end else if (clr_cnt == CW'(CLR_CYCLES - 1))
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (!calib_done)
                    state_nxt = IDLE;
                else if (frame_start) begin
                    state_nxt = CLR;
                    abort     = 1'b1;
                end else if (fifo_rdusedw >= {1'b0, chunk})
                    state_nxt = BURST;
            end
            BURST: begin
                // A frame_start seen during the burst wins over completion: the frame is not credited.
                if (wr_burst_finish) begin
                    if (!calib_done)
                        state_nxt = IDLE;
                    else if (pending || frame_start) begin
                        state_nxt = CLR;
                        abort     = 1'b1;
                    end else if (rem_after == '0)
                        state_nxt = DONE;
                    else
                        state_nxt = WAIT;
                end
            end
            DONE:    state_nxt = (frame_start && calib_done) ? CLR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            remaining     <= '0;
            addr          <= '0;
            buf_idx       <= 2'd0;
            last_buf      <= 2'd0;
            pending       <= 1'b0;
            wr_burst_len  <= 10'd0;
            wr_burst_addr <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLR && state_nxt == CLR && !abort) ? clr_cnt + 1'b1 : '0;
            pending <= (state == BURST && state_nxt == BURST && calib_done) ? (pending | frame_start) : 1'b0;
            if (state == CLR) begin
                remaining <= RW'(FRAME_WORDS);
                addr      <= ADDR_BITS'(buf_idx) * FRAME_STRIDE;
            end
            if (state == WAIT && state_nxt == BURST) begin
                wr_burst_len  <= chunk;
                wr_burst_addr <= addr;
            end
            if (state == BURST && wr_burst_finish) begin
                addr      <= addr + ADDR_BITS'(wr_burst_len);
                remaining <= rem_after;
            end
            if (state == DONE) begin
                last_buf <= buf_idx;
                buf_idx  <= (buf_idx == 2'(NUM_BUFS - 1)) ? 2'd0 : buf_idx + 2'd1;
            end
        end
    end

    assign fifo_aclr     = (state == CLR);
    assign wr_burst_req  = (state == BURST);
    assign fifo_rd_en    = wr_burst_req && wr_burst_data_req;
    assign wr_burst_data = wr_burst_req ? fifo_q : '0;
    assign frame_done    = (state == DONE);

`ifdef FRAME_WRITE_STAT_EN
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
            if (abort)         drop_cnt  <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Randomised bench for frame_write_ctrl: bench acts as FIFO and DDR burst controller,
// expected bursts/buffers are computed from frame arithmetic.
module tb_frame_write_ctrl;

    localparam int          BL     = 128;
    localparam int          FW     = 300;
    localparam int          NB     = 3;
    localparam logic [23:0] STRIDE = 24'h1000;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        calib_done = 1'b0;
    logic        frame_start = 1'b0;
    logic        fifo_aclr;
    logic [10:0] fifo_rdusedw = 11'd300;
    logic        fifo_rd_en;
    logic [63:0] fifo_q;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req = 1'b0;
    logic [63:0] wr_burst_data;
    logic        wr_burst_finish = 1'b0;
    logic        frame_done;
    logic [1:0]  last_buf;
`ifdef FRAME_WRITE_STAT_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    frame_write_ctrl #(
        .MEM_DATA_BITS(64), .ADDR_BITS(24), .BURST_LEN(BL), .FRAME_WORDS(FW),
        .FRAME_STRIDE(STRIDE), .NUM_BUFS(NB), .CLR_CYCLES(8)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .calib_done(calib_done), .frame_start(frame_start),
        .fifo_aclr(fifo_aclr), .fifo_rdusedw(fifo_rdusedw), .fifo_rd_en(fifo_rd_en), .fifo_q(fifo_q),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish), .frame_done(frame_done), .last_buf(last_buf)
`ifdef FRAME_WRITE_STAT_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 mem_clk = ~mem_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Show-ahead FIFO model: word i carries a salted, index-derived pattern.
    logic [31:0] salt = 32'h0;
    int unsigned word_idx = 0;

    function automatic logic [63:0] pat(input int unsigned i);
        return {(i * 32'h9E3779B9) ^ salt, i};
    endfunction

    assign fifo_q = pat(word_idx);
    always @(posedge mem_clk) if (fifo_rd_en) word_idx <= word_idx + 1;

    // Burst controller model with random data stalls.
    int phase = 0;
    int left  = 0;
    always begin
        @(posedge mem_clk); #1;
        if (!rst_n) begin
            phase = 0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        end else begin
            case (phase)
                0: begin
                    wr_burst_finish = 1'b0;
                    if (wr_burst_req) begin left = int'(wr_burst_len); phase = 1; end
                end
                1: begin
                    if (left == 0) begin
                        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b1; phase = 2;
                    end else begin
                        wr_burst_data_req = ($urandom_range(3) != 0);
                        if (wr_burst_data_req) left--;
                    end
                end
                default: begin wr_burst_finish = 1'b0; phase = 0; end
            endcase
        end
    end

    int          aclr_cycles = 0;
    int          rd_cycles   = 0;
    int          done_cnt    = 0;
    bit          req_prev    = 1'b0;
    int unsigned bq_len[$];
    int unsigned bq_addr[$];

    always @(negedge mem_clk) begin
        if (!rst_n) req_prev = 1'b0;
        else begin
            if (fifo_aclr) aclr_cycles++;
            chk("rd_en", fifo_rd_en, wr_burst_req & wr_burst_data_req);
            if (fifo_rd_en) begin
                rd_cycles++;
                chk("wdata", wr_burst_data, pat(word_idx));
            end
            if (wr_burst_req && !req_prev) begin
                bq_len.push_back(int'(wr_burst_len));
                bq_addr.push_back(int'(wr_burst_addr));
            end else if (wr_burst_req && bq_len.size() > 0) begin
                chk("len_hold", wr_burst_len, bq_len[$]);
                chk("addr_hold", wr_burst_addr, bq_addr[$]);
            end
            if (frame_done) done_cnt++;
            req_prev = wr_burst_req;
        end
    end

    int model_buf = 0;

    task automatic tick(input int n);
        repeat (n) begin @(posedge mem_clk); #1; end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
    endtask

    task automatic clear_counters();
        aclr_cycles = 0; rd_cycles = 0; done_cnt = 0;
        bq_len.delete(); bq_addr.delete();
    endtask

    task automatic finish_frame();
        int t;
        int w;
        int n;
        int len;
        int unsigned exp_addr;
        t = 0;
        while (done_cnt == 0 && t < 4000) begin tick(1); t++; end
        chk("frame_done_seen", (done_cnt != 0), 1);
        tick(2);
        chk("aclr_cycles", aclr_cycles, 8);
        chk("rd_cycles", rd_cycles, FW);
        chk("done_cnt", done_cnt, 1);
        chk("burst_count", bq_len.size(), (FW + BL - 1) / BL);
        w = 0; n = 0;
        while (w < FW && n < bq_len.size()) begin
            len      = (FW - w < BL) ? FW - w : BL;
            exp_addr = (model_buf * int'(STRIDE) + w) & 32'h00FF_FFFF;
            chk("burst_len", bq_len[n], len);
            chk("burst_addr", bq_addr[n], exp_addr);
            w += len; n++;
        end
        chk("last_buf", last_buf, model_buf);
        model_buf = (model_buf + 1) % NB;
        clear_counters();
    endtask

    initial begin
        int seen;
        int t;
        salt = $urandom;
        tick(2);
        chk("rst_aclr", fifo_aclr, 0);
        chk("rst_req", wr_burst_req, 0);
        chk("rst_len", wr_burst_len, 0);
        chk("rst_addr", wr_burst_addr, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_last_buf", last_buf, 0);
        chk("rst_data", wr_burst_data, 0);
`ifdef FRAME_WRITE_STAT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1; calib_done = 1'b1;
        tick(2);

        // normal frame followed by rotation through all buffers and back
        for (int f = 0; f < 4; f++) begin
            tick($urandom_range(1, 6));
            pulse_start();
            finish_frame();
        end
`ifdef FRAME_WRITE_STAT_EN
        chk("frame_cnt4", frame_cnt, 4);
`endif

        // starved FIFO
        fifo_rdusedw = 11'd127;
        pulse_start();
        seen = 0;
        repeat (30) begin tick(1); if (wr_burst_req) seen++; end
        chk("starved_req", seen, 0);
        fifo_rdusedw = 11'd128;
        chk("req_before_level", wr_burst_req, 0);
        tick(1);
        chk("req_after_level", wr_burst_req, 1);
        chk("len_after_level", wr_burst_len, 128);
        finish_frame();
        fifo_rdusedw = 11'd300;

        // abort during the second burst
        pulse_start();
        t = 0;
        while (bq_len.size() < 2 && t < 2000) begin tick(1); t++; end
        chk("second_burst_seen", bq_len.size(), 2);
        tick(3);
        pulse_start();
        t = 0;
        while (wr_burst_req && t < 2000) begin tick(1); t++; end
        chk("abort_aclr", fifo_aclr, 1);
        chk("abort_no_done", done_cnt, 0);
        clear_counters();
        finish_frame();
`ifdef FRAME_WRITE_STAT_EN
        chk("drop_cnt", drop_cnt, 1);
        chk("frame_cnt6", frame_cnt, 6);
`endif

        // calibration gating
        calib_done = 1'b0;
        tick(2);
        pulse_start();
        tick(20);
        chk("gated_aclr", aclr_cycles, 0);
        chk("gated_bursts", bq_len.size(), 0);
        chk("gated_req", wr_burst_req, 0);
        calib_done = 1'b1;
        tick(5);
        chk("gated_stays_idle", aclr_cycles, 0);

        // reset in the middle of a burst
        pulse_start();
        t = 0;
        while (!wr_burst_req && t < 2000) begin tick(1); t++; end
        chk("req_before_reset", wr_burst_req, 1);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", wr_burst_req, 0);
        chk("mid_rst_aclr", fifo_aclr, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_rst_len", wr_burst_len, 0);
        chk("mid_rst_addr", wr_burst_addr, 0);
        chk("mid_rst_data", wr_burst_data, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_last_buf", last_buf, 0);
        tick(3);
        rst_n = 1'b1;
        model_buf = 0;
        clear_counters();
        tick(2);
        pulse_start();
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
